// File: rtl/router_pkg.sv
// Shared constants and width helpers for the packet router sync block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

    // Default build: three output channels, 30-cycle stall timeout.
    localparam int DEF_NUM_CH  = 3;
    localparam int DEF_TIMEOUT = 30;

    // Address width. It is never narrower than one bit, so a two-channel
    // build still carries a real address.
    function automatic int addr_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // Stall counter width. It must be wide enough to hold TIMEOUT itself.
    function automatic int cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/stall_timer.sv
// Per-channel stall watchdog: one-cycle soft_reset pulse after TIMEOUT stalled cycles.
// Latency: pulse is registered, visible the cycle after the TIMEOUT-th stalled edge.
// Backpressure: none; observes vld/rd only. Repeats every TIMEOUT cycles while stalled.
//
// Ports:
//   clk, rst (async active-low)
//   vld        channel holds unread data
//   rd         downstream read this cycle
//   soft_reset registered flush pulse
module stall_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam int CNT_W = cnt_w(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             stall;

    assign stall = vld & ~rd;

    // The counter clears on the same edge that fires the pulse. A continuing
    // stall therefore starts a fresh TIMEOUT window, and the counter can
    // never wrap.
    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (stall) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchronizer: latches the header address, steers write enable and full flag, and watches channels for stalls.
// Latency: wr_en, fifo_full and vld_out are combinational; addr_err and soft_reset are registered (1 cycle).
// Backpressure: fifo_full mirrors the addressed channel. Invalid addresses drop writes and never stall.
//
// Ports:
//   clk, rst (async active-low)
//   din/detect_addr   header address and its strobe
//   wr_en_reg         upstream write request
//   full/empty/rd_en  per-channel FIFO status and downstream read
//   wr_en             one-hot FIFO write enable
//   fifo_full         full flag of the addressed channel
//   vld_out           per-channel data valid
//   soft_reset        per-channel flush pulse
//   addr_err          one-cycle pulse for an out-of-range address
module router_sync_n
    import router_pkg::*;
#(
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int ADDR_W  = addr_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] din,
    input  logic              detect_addr,
    input  logic              wr_en_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] rd_en,
    output logic [NUM_CH-1:0] wr_en,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    // One extra bit, so NUM_CH itself fits when it is a power of two.
    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_vld_q, addr_vld_d;
    logic              addr_err_q, addr_err_d;
    logic              din_in_range;

    assign din_in_range = ({1'b0, din} < NUM_CH_W);

    always_comb begin
        addr_d     = addr_q;
        addr_vld_d = addr_vld_q;
        addr_err_d = 1'b0;
        if (detect_addr) begin
            addr_d     = din;
            addr_vld_d = din_in_range;
            addr_err_d = ~din_in_range;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Steering uses the latched address only. A header strobe in the same
    // cycle as a write therefore takes effect one cycle later.
    always_comb begin
        wr_en     = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_vld_q && (addr_q == ADDR_W'(i))) begin
                wr_en[i]  = wr_en_reg;
                fifo_full = full[i];
            end
        end
    end

    assign vld_out  = ~empty;
    assign addr_err = addr_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        stall_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_stall_timer (
            .clk        (clk),
            .rst        (rst),
            .vld        (vld_out[g]),
            .rd         (rd_en[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n (NUM_CH=3, TIMEOUT=30).
// Latency: stimulus changes 1 time unit after posedge; the monitor checks at negedge.
// Backpressure: n/a.
module tb_router_sync_n;

    localparam int NUM_CH  = 3;
    localparam int TIMEOUT = 30;

    localparam int S_WR_EN   = 0;
    localparam int S_FFULL   = 1;
    localparam int S_VLD     = 2;
    localparam int S_SRST    = 3;
    localparam int S_ADDRERR = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        din;
    logic              detect_addr;
    logic              wr_en_reg;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] rd_en;
    logic [NUM_CH-1:0] wr_en;
    logic              fifo_full;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] soft_reset;
    logic              addr_err;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    bit   done = 0;

    router_sync_n #(
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .detect_addr (detect_addr),
        .wr_en_reg   (wr_en_reg),
        .full        (full),
        .empty       (empty),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .fifo_full   (fifo_full),
        .vld_out     (vld_out),
        .soft_reset  (soft_reset),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_WR_EN:   return 32'(wr_en);
            S_FFULL:   return 32'(fifo_full);
            S_VLD:     return 32'(vld_out);
            S_SRST:    return 32'(soft_reset);
            default:   return 32'(addr_err);
        endcase
    endfunction

    task automatic expect_sig(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: at every negedge, check all pending expectations against the DUT.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.sel);
                tests_run++;
                if (a !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %0h expected %0h at %0t", e.name, a, e.exp, $time);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: bench did not complete");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        rst = 1'b0; din = '0; detect_addr = 1'b0; wr_en_reg = 1'b0;
        full = '0; empty = '1; rd_en = '0;
        #2;
        // Reset state
        wr_en_reg = 1'b1; full = '1;
        expect_sig("rst_wr_en", S_WR_EN, 0);
        expect_sig("rst_ffull", S_FFULL, 0);
        expect_sig("rst_addr_err", S_ADDRERR, 0);
        expect_sig("rst_srst", S_SRST, 0);
        expect_sig("rst_vld", S_VLD, 0);
        tick();
        rst = 1'b1;
        expect_sig("post_rst_wr_en", S_WR_EN, 0);
        expect_sig("post_rst_ffull", S_FFULL, 0);
        tick();

        // Address 2: write steering and full flag
        wr_en_reg = 1'b0; full = '0;
        detect_addr = 1'b1; din = 2'd2;
        expect_sig("a2_pre_wr_en", S_WR_EN, 0);
        tick();
        detect_addr = 1'b0; wr_en_reg = 1'b1; full = 3'b100;
        expect_sig("a2_wr_en", S_WR_EN, 3'b100);
        expect_sig("a2_ffull", S_FFULL, 1);
        expect_sig("a2_addr_err", S_ADDRERR, 0);
        tick();
        full = 3'b011;
        expect_sig("a2_ffull_other", S_FFULL, 0);
        tick();

        // Same-cycle header and write use the previously latched address
        wr_en_reg = 1'b0; detect_addr = 1'b1; din = 2'd0;
        tick();
        detect_addr = 1'b1; din = 2'd1; wr_en_reg = 1'b1;
        expect_sig("same_cyc_old", S_WR_EN, 3'b001);
        tick();
        detect_addr = 1'b0;
        expect_sig("same_cyc_new", S_WR_EN, 3'b010);
        tick();

        // Out-of-range address
        detect_addr = 1'b1; din = 2'd3; full = 3'b111;
        expect_sig("bad_old_wr_en", S_WR_EN, 3'b010);
        expect_sig("bad_err_pre", S_ADDRERR, 0);
        tick();
        detect_addr = 1'b0;
        expect_sig("bad_err_pulse", S_ADDRERR, 1);
        expect_sig("bad_wr_en", S_WR_EN, 0);
        expect_sig("bad_ffull", S_FFULL, 0);
        tick();
        expect_sig("bad_err_clear", S_ADDRERR, 0);
        tick();

        // Restore a valid address and stop writing
        detect_addr = 1'b1; din = 2'd0; wr_en_reg = 1'b0; full = '0;
        tick();
        detect_addr = 1'b0;

        // Channel 0 stalled: pulses after the 30th and 60th edges
        empty = 3'b110; rd_en = '0;
        expect_sig("ch0_vld", S_VLD, 3'b001);
        expect_sig("ch0_srst_start", S_SRST, 0);
        for (int k = 1; k <= 62; k++) begin
            tick();
            expect_sig($sformatf("ch0_stall_%0d", k), S_SRST,
                       ((k % TIMEOUT) == 0) ? 32'd1 : 32'd0);
        end
        empty = 3'b111;
        tick();
        expect_sig("ch0_idle", S_SRST, 0);
        tick();

        // Channel 1: 29 stalls, a read, 29 stalls (quiet), then a 30th stall (pulse)
        empty = 3'b101;
        for (int k = 1; k <= 29; k++) begin
            tick();
            expect_sig($sformatf("ch1_a_%0d", k), S_SRST, 0);
        end
        rd_en = 3'b010;
        tick();
        expect_sig("ch1_read", S_SRST, 0);
        rd_en = '0;
        for (int k = 1; k <= 29; k++) begin
            tick();
            expect_sig($sformatf("ch1_b_%0d", k), S_SRST, 0);
        end
        tick();
        expect_sig("ch1_b_30", S_SRST, 3'b010);
        empty = 3'b111;
        tick();
        tick();

        // Reset in the middle of a stall discards the partial count
        empty = 3'b110;
        for (int k = 1; k <= 20; k++) begin
            tick();
        end
        #2;
        rst = 1'b0; wr_en_reg = 1'b1; full = 3'b111;
        expect_sig("mid_rst_wr_en", S_WR_EN, 0);
        expect_sig("mid_rst_ffull", S_FFULL, 0);
        expect_sig("mid_rst_srst", S_SRST, 0);
        expect_sig("mid_rst_err", S_ADDRERR, 0);
        tick();
        expect_sig("mid_rst_srst2", S_SRST, 0);
        tick();
        rst = 1'b1;
        expect_sig("rel_wr_en", S_WR_EN, 0);
        for (int k = 1; k <= 31; k++) begin
            tick();
            expect_sig($sformatf("rel_stall_%0d", k), S_SRST,
                       (k == TIMEOUT) ? 32'd1 : 32'd0);
        end
        wr_en_reg = 1'b0; full = '0;
        empty = 3'b111;
        tick();
        tick();

        // All channels stalled together: simultaneous pulses
        empty = 3'b000;
        expect_sig("all_vld", S_VLD, 3'b111);
        for (int k = 1; k <= 30; k++) begin
            tick();
            expect_sig($sformatf("all_stall_%0d", k), S_SRST,
                       (k == TIMEOUT) ? 32'd7 : 32'd0);
        end
        empty = 3'b111;
        tick();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        done = 1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/router_sync_n.md
ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 Parameter NUM_CH, default 3, number of output channels; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 30, consecutive unread-valid cycles before a channel soft reset; legal range 2..255.
REQ-003 Derived constant ADDR_W = max(1, clog2(NUM_CH)); derived constant CNT_W = clog2(TIMEOUT+1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 din  input  ADDR_W  destination address from packet header.
REQ-007 detect_addr  input  1  header-valid strobe; latches din.
REQ-008 wr_en_reg  input  1  upstream FSM write request.
REQ-009 full  input  NUM_CH  per-channel FIFO full.
REQ-010 empty  input  NUM_CH  per-channel FIFO empty.
REQ-011 rd_en  input  NUM_CH  per-channel downstream read.
REQ-012 wr_en  output  NUM_CH  one-hot FIFO write enable.
REQ-013 fifo_full  output  1  full flag of the addressed channel.
REQ-014 vld_out  output  NUM_CH  per-channel data valid.
REQ-015 soft_reset  output  NUM_CH  per-channel FIFO flush pulse.
REQ-016 addr_err  output  1  one-cycle pulse, out-of-range address latched.

Function
REQ-017 Address register SHALL load din on each rising edge with detect_addr=1, otherwise hold.
REQ-018 Address valid flag SHALL load (din < NUM_CH) with the address register.
REQ-019 wr_en SHALL be combinational: bit[addr]=wr_en_reg when address valid; all zero when address invalid.
REQ-020 detect_addr and wr_en_reg in the same cycle: wr_en SHALL use the previously latched address; the new address applies from the next cycle.
REQ-021 fifo_full SHALL equal full[addr] combinationally when address valid, 0 when invalid (packet dropped, no stall).
REQ-022 addr_err SHALL be registered, 1 for exactly the cycle after a detect_addr edge with din >= NUM_CH, else 0.
REQ-023 vld_out[i] SHALL equal ~empty[i] combinationally.
REQ-024 Per channel, a CNT_W-bit stall counter SHALL increment on each edge where vld_out[i]=1 and rd_en[i]=0.
REQ-025 An edge with rd_en[i]=1 or empty[i]=1 SHALL clear counter i and drive soft_reset[i]=0.
REQ-026 On an edge where the stall condition holds and counter i = TIMEOUT-1, soft_reset[i] SHALL go 1 and counter i SHALL clear.
REQ-027 soft_reset[i] SHALL be a registered single-cycle pulse, first asserted after exactly TIMEOUT consecutive stalled cycles; stalling continuing afterwards SHALL produce a further pulse every TIMEOUT cycles.
REQ-028 Counters SHALL never wrap; channels SHALL be fully independent, with simultaneous pulses on several channels permitted.

Reset
REQ-029 rst=0 SHALL asynchronously clear the address register, valid flag (to 0, invalid), all counters, soft_reset, and addr_err.
REQ-030 During and after reset, until the first detect_addr, wr_en SHALL be all zero and fifo_full 0.
REQ-031 Reset asserted mid-stall SHALL discard the partial count; counting restarts from 0 after release.

Structure
REQ-032 Package router_pkg SHALL hold ADDR_W/CNT_W derivation functions and default NUM_CH and TIMEOUT constants.
REQ-033 The per-channel counter and pulse SHALL be a sub-module stall_timer (parameter TIMEOUT; inputs clk, rst, vld, rd; output soft_reset), generated NUM_CH times.

Verification
REQ-034 NUM_CH=3: detect_addr with din=2, then wr_en_reg=1 -> wr_en=3'b100; full=3'b100 -> fifo_full=1.
REQ-035 detect_addr din=1 with wr_en_reg=1 in the same cycle, prior addr=0 -> wr_en=3'b001 that cycle, 3'b010 next cycle.
REQ-036 NUM_CH=3: din=3 with detect_addr -> addr_err pulses once; wr_en_reg=1 -> wr_en=0, fifo_full=0.
REQ-037 TIMEOUT=30: empty[0]=0 and rd_en[0]=0 held -> soft_reset[0] high for 1 cycle after the 30th edge; again after the 60th.
REQ-038 Stall on channel 1 for 29 cycles, one rd_en[1] pulse, then 29 more stalled cycles -> no soft_reset[1].
REQ-039 rst asserted asynchronously at stall count 20, released, stall resumes -> soft_reset 30 cycles after release; all outputs 0 during reset.
